// File: rtl/snn_conv1_pkg.sv
// snn_conv1 shared constants, state encoding and kernel weight function.
// Optional frame load port set: CONV_1_1_INPUT_LOAD_EN.
package snn_conv1_pkg;

  localparam int W_DEF   = 32;
  localparam int IC_DEF  = 3;
  localparam int OC_DEF  = 64;
  localparam int K_DEF   = 3;
  localparam int THR_DEF = 1;

  localparam int TAPS  = IC_DEF * K_DEF * K_DEF;
  localparam int AW    = $clog2(W_DEF * W_DEF);
  localparam int ACC_W = 10;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_FIRE = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // (v mod 16) - 8 is just v[3:0] with the MSB flipped.
  function automatic logic signed [3:0] weight(
    input int oc,
    input int ic,
    input int ky,
    input int kx
  );
    logic [3:0] v;
    v = 4'(oc * 7 + ic * 5 + ky * 3 + kx);
    return v ^ 4'h8;
  endfunction

endpackage

// File: rtl/snn_conv1_core_lane.sv
// snn_lif_lane: one output channel accumulator with threshold compare.
// Optional frame load port set: CONV_1_1_INPUT_LOAD_EN (not used here).
module snn_lif_lane
  import snn_conv1_pkg::*;
#(
  parameter int OC_IDX    = 0,
  parameter int THRESHOLD = THR_DEF,
  parameter int ICW       = 2,
  parameter int KW        = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           add_en,
  input  logic [ICW-1:0] ic,
  input  logic [KW-1:0]  ky,
  input  logic [KW-1:0]  kx,
  output logic           spike
);

  localparam logic signed [ACC_W-1:0] THR = ACC_W'(THRESHOLD);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [3:0]       w;

  always_comb begin
    w     = weight(OC_IDX, int'(ic), int'(ky), int'(kx));
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + ACC_W'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign spike = (acc_q >= THR);

endmodule

// File: rtl/snn_conv1_core.sv
// snn_conv1_core: conv_1_1 spiking layer, one tap per cycle, OC parallel lanes.
// Optional frame load port set: CONV_1_1_INPUT_LOAD_EN.
module snn_conv1_core
  import snn_conv1_pkg::*;
#(
  parameter int CONV_1_1_INPUT_FRAME_WIDTH = W_DEF,
  parameter int CONV_1_1_INPUT_CHANNELS    = IC_DEF,
  parameter int CONV_1_1_OUTPUT_CHANNELS   = OC_DEF,
  parameter int CONV_1_1_KERNEL_SIZE       = K_DEF,
  parameter int THRESHOLD                  = THR_DEF,
  localparam int W   = CONV_1_1_INPUT_FRAME_WIDTH,
  localparam int IC  = CONV_1_1_INPUT_CHANNELS,
  localparam int OC  = CONV_1_1_OUTPUT_CHANNELS,
  localparam int K   = CONV_1_1_KERNEL_SIZE,
  localparam int PAW = $clog2(W * W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           input_avail,
  output logic           conv_1_1_avail,
`ifdef CONV_1_1_INPUT_LOAD_EN
  input  logic           in_we,
  input  logic [PAW-1:0] in_addr,
  input  logic [IC-1:0]  in_data,
`endif
  input  logic [PAW-1:0] out_addr,
  output logic [OC-1:0]  out_spikes
);

  localparam int XW  = $clog2(W + 1);
  localparam int ICW = $clog2(IC + 1);
  localparam int KW  = $clog2(K + 1);
  localparam int PAD = (K - 1) / 2;

  state_t         state_q, state_d;
  logic           avail_q, avail_d;
  logic           edge_q, edge_d;
  logic [XW-1:0]  x_q, x_d, y_q, y_d;
  logic [ICW-1:0] ic_q, ic_d;
  logic [KW-1:0]  ky_q, ky_d, kx_q, kx_d;

  logic           add_en;
  logic           clr;
  logic           map_we;
  logic           tap_bit;
  logic           in_frame;
  logic [PAW-1:0] nb_addr;
  logic [PAW-1:0] pix_addr;
  logic [OC-1:0]  spikes;
  int             nx, ny;

  logic [OC-1:0]  map_q [W*W];

  always_comb begin
    ny       = int'(y_q) + int'(ky_q) - PAD;
    nx       = int'(x_q) + int'(kx_q) - PAD;
    in_frame = (ny >= 0) && (ny < W) && (nx >= 0) && (nx < W);
    nb_addr  = PAW'(ny * W + nx);
    pix_addr = PAW'(int'(y_q) * W + int'(x_q));
  end

`ifdef CONV_1_1_INPUT_LOAD_EN
  logic [IC-1:0] frame_q [W*W];

  always_ff @(posedge clk) begin
    if (in_we && state_q == S_IDLE) begin
      frame_q[in_addr] <= in_data;
    end
  end

  assign tap_bit = in_frame && frame_q[nb_addr][ic_q];
`else
  assign tap_bit = in_frame && (((nx + ny + int'(ic_q)) % 3) == 0);
`endif

  always_comb begin
    state_d = state_q;
    avail_d = avail_q;
    edge_d  = input_avail;
    x_d     = x_q;
    y_d     = y_q;
    ic_d    = ic_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    add_en  = 1'b0;
    clr     = 1'b0;
    map_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (input_avail && !edge_q) begin
          state_d = S_SCAN;
          avail_d = 1'b0;
          x_d     = '0;
          y_d     = '0;
          ic_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      S_SCAN: begin
        add_en = tap_bit;
        kx_d   = kx_q + 1'b1;
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + 1'b1;
          if (ky_q == KW'(K - 1)) begin
            ky_d = '0;
            ic_d = ic_q + 1'b1;
            if (ic_q == ICW'(IC - 1)) begin
              ic_d    = '0;
              state_d = S_FIRE;
            end
          end
        end
      end
      S_FIRE: begin
        map_we  = 1'b1;
        clr     = 1'b1;
        state_d = S_SCAN;
        x_d     = x_q + 1'b1;
        if (x_q == XW'(W - 1)) begin
          x_d = '0;
          y_d = y_q + 1'b1;
          if (y_q == XW'(W - 1)) begin
            y_d     = '0;
            state_d = S_DONE;
          end
        end
      end
      default: begin
        avail_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      avail_q <= 1'b0;
      edge_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ic_q    <= '0;
      ky_q    <= '0;
      kx_q    <= '0;
    end else begin
      state_q <= state_d;
      avail_q <= avail_d;
      edge_q  <= edge_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ic_q    <= ic_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
    end
  end

  for (genvar g = 0; g < OC; g++) begin : g_lane
    snn_lif_lane #(
      .OC_IDX   (g),
      .THRESHOLD(THRESHOLD),
      .ICW      (ICW),
      .KW       (KW)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .add_en(add_en),
      .ic    (ic_q),
      .ky    (ky_q),
      .kx    (kx_q),
      .spike (spikes[g])
    );
  end

  always_ff @(posedge clk) begin
    if (map_we) begin
      map_q[pix_addr] <= spikes;
    end
  end

  assign out_spikes     = map_q[out_addr];
  assign conv_1_1_avail = avail_q;

endmodule

// File: tb/tb_snn_conv1_core.sv
// Bench for snn_conv1_core: latency, start handling and full spike map.
// Exercises the frame load path when CONV_1_1_INPUT_LOAD_EN is defined.
module tb_snn_conv1_core;

  localparam int W   = 32;
  localparam int NP  = W * W;
  localparam int IC  = 3;
  localparam int OC  = 64;
  localparam int LAT = 1 + NP * (IC * 9 + 1) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          input_avail = 1'b0;
  logic [9:0]    out_addr = '0;
  logic          avail_a, avail_b;
  logic [OC-1:0] sp_a, sp_b;
`ifdef CONV_1_1_INPUT_LOAD_EN
  logic          in_we = 1'b0;
  logic [9:0]    in_addr = '0;
  logic [2:0]    in_data = '0;
`endif

  int total = 0;
  int bad   = 0;

  bit [2:0]      frame [NP];
  logic [OC-1:0] exp_a [NP];
  logic [OC-1:0] exp_b [NP];

  always #5 clk = ~clk;

  snn_conv1_core #(.THRESHOLD(1)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .input_avail   (input_avail),
    .conv_1_1_avail(avail_a),
`ifdef CONV_1_1_INPUT_LOAD_EN
    .in_we         (in_we),
    .in_addr       (in_addr),
    .in_data       (in_data),
`endif
    .out_addr      (out_addr),
    .out_spikes    (sp_a)
  );

  snn_conv1_core #(.THRESHOLD(10)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .input_avail   (input_avail),
    .conv_1_1_avail(avail_b),
`ifdef CONV_1_1_INPUT_LOAD_EN
    .in_we         (in_we),
    .in_addr       (in_addr),
    .in_data       (in_data),
`endif
    .out_addr      (out_addr),
    .out_spikes    (sp_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit pix_in(int ic, int y, int x);
    if (y < 0 || y >= W || x < 0 || x >= W) return 1'b0;
    return frame[y * W + x][ic];
  endfunction

  // Direct convolution from the kernel formula, one pixel at a time.
  task automatic build_model();
    for (int p = 0; p < NP; p++) begin
      int y, x;
      y = p / W;
      x = p % W;
      for (int oc = 0; oc < OC; oc++) begin
        int m;
        m = 0;
        for (int ic = 0; ic < IC; ic++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              if (pix_in(ic, y + ky - 1, x + kx - 1))
                m += ((oc * 7 + ic * 5 + ky * 3 + kx) % 16) - 8;
        exp_a[p][oc] = (m >= 1);
        exp_b[p][oc] = (m >= 10);
      end
    end
  endtask

  task automatic check_map(input string tag);
    int off, stride;
    off    = $urandom_range(0, NP - 1);
    stride = 2 * $urandom_range(0, 200) + 1;
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (off + i * stride) % NP;
      @(negedge clk);
      out_addr = 10'(p);
      #1;
      chk({tag, "_a"}, 64'(sp_a), 64'(exp_a[p]));
      chk({tag, "_b"}, 64'(sp_b), 64'(exp_b[p]));
    end
  endtask

  // Returns posedges from raising input_avail until avail_a is seen high.
  task automatic run_frame(input int hold, input bit check_drop);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    @(negedge clk);
    input_avail = 1'b1;
    while (!done && n < LAT + 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (check_drop && n == 1) chk("avail_drop", 64'(avail_a), 64'd0);
      if (hold > 0 && n == hold) input_avail = 1'b0;
      if (avail_a) done = 1'b1;
    end
    chk("latency", 64'(n), 64'(LAT));
    chk("avail_b", 64'(avail_b), 64'd1);
  endtask

`ifdef CONV_1_1_INPUT_LOAD_EN
  task automatic load_frame();
    for (int p = 0; p < NP; p++) begin
      @(negedge clk);
      in_we   = 1'b1;
      in_addr = 10'(p);
      in_data = frame[p];
    end
    @(negedge clk);
    in_we = 1'b0;
  endtask
`endif

  initial begin
    for (int p = 0; p < NP; p++)
      for (int ic = 0; ic < IC; ic++)
        frame[p][ic] = (((p % W) + (p / W) + ic) % 3) == 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_avail_a", 64'(avail_a), 64'd0);
    chk("rst_avail_b", 64'(avail_b), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef CONV_1_1_INPUT_LOAD_EN
    load_frame();
`endif

    @(negedge clk);
    input_avail = 1'b1;
    repeat ($urandom_range(3, 25)) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    input_avail = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midscan_rst", 64'(avail_a), 64'd0);
    repeat ($urandom_range(40, 90)) @(posedge clk);
    #1;
    chk("idle_after_rst", 64'(avail_a), 64'd0);

    build_model();
    run_frame(20, 1'b0);
    @(negedge clk);
    out_addr = '0;
    #1;
    chk("pix0_thr1", 64'(sp_a[2:0]), 64'(3'b101));
    chk("pix0_thr10", 64'(sp_b[2:0]), 64'(3'b000));
    check_map("map1");

    @(negedge clk);
    input_avail = 1'b0;
    repeat ($urandom_range(2, 10)) @(posedge clk);
    run_frame(0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    chk("no_retrigger", 64'(avail_a), 64'd1);
    @(negedge clk);
    input_avail = 1'b0;
    check_map("map2");

`ifdef CONV_1_1_INPUT_LOAD_EN
    for (int p = 0; p < NP; p++) frame[p] = 3'b000;
    load_frame();
    build_model();
    run_frame(5, 1'b1);
    check_map("map_zero");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      out_addr = 10'($urandom_range(0, NP - 1));
      #1;
      chk("zero_word", 64'(sp_a), 64'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_conv1_core.md
Name: snn_conv1_core

Overview:
- First spiking convolution layer (conv_1_1) of the SNN accelerator, wrapped as a self-contained top.
- On a start request it convolves a 3-channel binary spike frame with a fixed signed INT4 3x3 kernel bank for every output channel.
- Each membrane sum is thresholded into one output spike per (channel, pixel); results are stored in an internal spike map.
- Asserts conv_1_1_avail when the map is complete.

Parameters:
- CONV_1_1_INPUT_FRAME_WIDTH, 32, frame width = height (W); frame size W*W.
- CONV_1_1_INPUT_CHANNELS, 3, input spike channels (IC).
- CONV_1_1_OUTPUT_CHANNELS, 64, output channels (OC), all computed in parallel lanes.
- CONV_1_1_KERNEL_SIZE, 3, square kernel size (K); padding (K-1)/2, stride 1.
- THRESHOLD, 1, signed firing threshold; spike iff membrane >= THRESHOLD.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- input_avail  in  1  start request (level); a rising edge seen in IDLE starts one frame.
- conv_1_1_avail  out  1  level; high = output spike map valid.
- out_addr  in  log2(W*W)  pixel index y*W+x for readout.
- out_spikes  out  OC  spikes of all channels at out_addr; combinational read of the map.

Behaviour:
- Input frame is fixed (without LOAD_EN): in[ic][y][x] = 1 iff (x+y+ic) mod 3 == 0.
- Weights: w[oc][ic][ky][kx] = ((oc*7 + ic*5 + ky*3 + kx) mod 16) - 8, signed 4-bit.
- Neighbour pixel = (y+ky-1, x+kx-1). Out-of-frame taps contribute 0 (zero padding).
- Accumulators: OC lanes x 10-bit signed. Worst case ±216 with IC=3, K=3; no saturation needed.
- FSM states:
  - IDLE: wait for input_avail rising edge, detected against a registered copy.
  - SCAN: one tap per cycle, order ic, then ky, then kx (IC*K*K = 27 cycles). Add w to each lane when the tap spike is 1.
  - FIRE: 1 cycle. Write the OC-bit compare vector to map[y*W+x] and clear the accumulators. Advance x, then y; after the last pixel go to DONE, otherwise back to SCAN.
  - DONE: set conv_1_1_avail, go to IDLE.
- Latency: start edge to conv_1_1_avail high = 1 + (W*W)*(IC*K*K+1) + 1 cycles (28674 at defaults). Fixed and data-independent.
- conv_1_1_avail stays high until the next accepted start, which clears it in the same cycle the FSM leaves IDLE.
- input_avail is ignored outside IDLE; a level held high does not retrigger.
- Reset values: state IDLE, conv_1_1_avail 0, counters 0, accumulators 0, edge register 0. Map contents are undefined after reset.
- Reset mid-frame aborts immediately; a new rising edge is needed afterwards.

Optional Feature:
- Macro CONV_1_1_INPUT_LOAD_EN.
- Defined: adds ports in_we (1), in_addr (log2(W*W)), in_data (IC). The internal IC-bit-per-pixel frame RAM is written when in_we=1 in IDLE; writes in other states are ignored. Contents persist across frames and are undefined after reset.
- Undefined: the frame comes from the fixed pattern above and no extra ports exist.

Decomposition:
- Package snn_conv1_pkg holds default parameters, the derived constants (taps, address width, accumulator width), the state enum, and a weight function.
- One sub-module, snn_lif_lane: one output channel's accumulator, weight lookup and threshold compare, instantiated OC times.

Test Plan:
- Reset held 2 cycles mid-SCAN -> conv_1_1_avail=0, FSM in IDLE, no map writes.
- Pulse input_avail high for 20 cycles -> exactly one frame; conv_1_1_avail rises 28674 cycles after the edge.
- After done, out_addr=0 -> out_spikes[2:0]=3'b101 (oc0 membrane 1, oc1 -3, oc2 9).
- THRESHOLD=10, out_addr=0 -> out_spikes[2:0]=3'b000.
- Second input_avail edge after done -> conv_1_1_avail drops next cycle, rises again after the same latency, map identical.
- With CONV_1_1_INPUT_LOAD_EN, load an all-zero frame -> every out_spikes word 0 for THRESHOLD=1.
